shared_bus_arbiter: RTL and testbench

SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

---
 rtl/shared_bus_arbiter_pkg.sv | 27 ++
 rtl/shared_bus_arbiter_rr_pick3.sv | 42 ++++
 rtl/shared_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_shared_bus_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_bus_arbiter_pkg.sv
// rtl/shared_bus_arbiter_pkg.sv - shared encodings for the three-requester bus arbiter
//
// Holds the shared-mux select codes, the arbiter FSM state encoding, the
// default burst limit and the round-robin pointer advance helper.
package shared_bus_arbiter_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  localparam int MAX_BEATS_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arbState_t;

  // Pointer advance after a release: owner+1 mod 3, never producing 3.
  function automatic logic [1:0] nextPtr(input logic [1:0] owner);
    case (owner)
      SEL_A:   nextPtr = SEL_B;
      SEL_B:   nextPtr = SEL_C;
      default: nextPtr = SEL_A;
    endcase
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_pick3.sv
// rtl/shared_bus_arbiter_rr_pick3.sv - combinational round-robin pick among three requesters
//
// Ports:
//   req   in  3  request vector (bit0 A, bit1 B, bit2 C)
//   ptr   in  2  round-robin pointer, first candidate to consider
//   pick  out 3  one-hot winner, 000 when nothing requests
//   idx   out 2  encoded winner (SEL_A when nothing requests)
module rr_pick3
  import shared_bus_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] pick,
  output logic [1:0] idx
);

  logic [1:0] base;
  logic [2:0] cand;
  logic       found;

  // A pointer of 3 cannot occur, but is folded onto A so the search stays defined.
  assign base = (ptr == 2'd3) ? SEL_A : ptr;

  always_comb begin
    pick  = 3'b000;
    idx   = SEL_A;
    found = 1'b0;
    cand  = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, base} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (!found && req[cand[1:0]]) begin
        pick[cand[1:0]] = 1'b1;
        idx             = cand[1:0];
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// rtl/shared_bus_arbiter.sv - round-robin arbiter muxing three bursting requesters onto one bus
//
// Ports:
//   Clk                 in  1   sole clock, rising edge
//   Reset               in  1   asynchronous active-low reset
//   ReqA/ReqB/ReqC      in  1   requester wants the bus / has a valid beat
//   DataA/DataB/DataC   in  32  requester beat data
//   LastA/LastB/LastC   in  1   current beat closes the burst
//   Gnt                 out 3   registered one-hot owner
//   Ready               out 3   per-requester accept strobe
//   Sel                 out 2   registered shared-mux select
//   OutData             out 32  registered shared-bus word
//   OutValid            out 1   OutData holds an unconsumed beat
//   OutReady            in  1   downstream consumes OutData this cycle
//   Busy                out 1   arbiter currently owns the bus for someone
//
// MAX_BEATS must lie in 1..15 (four-bit beat counter).
module shared_bus_arbiter
  import shared_bus_arbiter_pkg::*;
#(
  parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqA,
  input  logic        ReqB,
  input  logic        ReqC,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  input  logic [31:0] DataC,
  input  logic        LastA,
  input  logic        LastB,
  input  logic        LastC,
  output logic [2:0]  Gnt,
  output logic [2:0]  Ready,
  output logic [1:0]  Sel,
  output logic [31:0] OutData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Busy
);

  localparam logic [3:0] BEAT_LIMIT = 4'(MAX_BEATS);

  arbState_t   state;
  arbState_t   stateNext;
  logic [2:0]  gnt;
  logic [2:0]  gntNext;
  logic [1:0]  sel;
  logic [1:0]  selNext;
  logic [1:0]  ptr;
  logic [1:0]  ptrNext;
  logic [3:0]  count;
  logic [3:0]  countNext;
  logic [31:0] outData;
  logic        outValid;

  logic [2:0]  reqVec;
  logic [2:0]  lastVec;
  logic [2:0]  pick;
  logic [1:0]  pickIdx;
  logic [2:0]  ready;
  logic        ownerReq;
  logic        ownerLast;
  logic        accept;
  logic [3:0]  countInc;
  logic [31:0] ownerData;

  assign reqVec  = {ReqC, ReqB, ReqA};
  assign lastVec = {LastC, LastB, LastA};

  rr_pick3 uPick (
    .req  (reqVec),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pickIdx)
  );

  // The output register can take a new beat when empty or being drained this cycle.
  assign ready     = gnt & {3{~outValid | OutReady}};
  assign ownerReq  = |(gnt & reqVec);
  assign ownerLast = |(gnt & lastVec);
  assign accept    = |(ready & reqVec);
  assign countInc  = count + 4'd1;

  always_comb begin
    case (sel)
      SEL_B:   ownerData = DataB;
      SEL_C:   ownerData = DataC;
      default: ownerData = DataA;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      gnt   <= 3'b000;
      sel   <= SEL_A;
      ptr   <= SEL_A;
      count <= 4'd0;
    end else begin
      state <= stateNext;
      gnt   <= gntNext;
      sel   <= selNext;
      ptr   <= ptrNext;
      count <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    gntNext   = gnt;
    selNext   = sel;
    ptrNext   = ptr;
    countNext = count;
    case (state)
      ST_IDLE: begin
        gntNext = 3'b000;
        if (|reqVec) begin
          stateNext = ST_OWN;
          gntNext   = pick;
          selNext   = pickIdx;
          countNext = 4'd0;
        end
      end
      ST_OWN: begin
        if (accept) begin
          countNext = countInc;
        end
        // An owner dropping Req cannot have a beat accepted, so the two
        // release causes never collide.
        if (!ownerReq || (accept && (ownerLast || countInc == BEAT_LIMIT))) begin
          stateNext = ST_IDLE;
          gntNext   = 3'b000;
          ptrNext   = nextPtr(sel);
        end
      end
      default: begin
        stateNext = ST_IDLE;
        gntNext   = 3'b000;
      end
    endcase
  end

  // Output register is independent of the grant: a pending beat survives
  // release and the following grant until the downstream takes it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      outData  <= 32'd0;
      outValid <= 1'b0;
    end else if (accept) begin
      outData  <= ownerData;
      outValid <= 1'b1;
    end else if (OutReady) begin
      outValid <= 1'b0;
    end
  end

  assign Gnt      = gnt;
  assign Ready    = ready;
  assign Sel      = sel;
  assign OutData  = outData;
  assign OutValid = outValid;
  assign Busy     = (state == ST_OWN);

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// tb/tb_shared_bus_arbiter.sv - directed self-checking bench for shared_bus_arbiter
module tb_shared_bus_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqA, ReqB, ReqC;
  logic [31:0] DataA, DataB, DataC;
  logic        LastA, LastB, LastC;
  logic [2:0]  Gnt;
  logic [2:0]  Ready;
  logic [1:0]  Sel;
  logic [31:0] OutData;
  logic        OutValid;
  logic        OutReady;
  logic        Busy;

  int passed = 0;
  int total  = 0;

  shared_bus_arbiter #(.MAX_BEATS(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqA     (ReqA),
    .ReqB     (ReqB),
    .ReqC     (ReqC),
    .DataA    (DataA),
    .DataB    (DataB),
    .DataC    (DataC),
    .LastA    (LastA),
    .LastB    (LastB),
    .LastC    (LastC),
    .Gnt      (Gnt),
    .Ready    (Ready),
    .Sel      (Sel),
    .OutData  (OutData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearInputs();
    ReqA = 0; ReqB = 0; ReqC = 0;
    LastA = 0; LastB = 0; LastC = 0;
    DataA = 0; DataB = 0; DataC = 0;
    OutReady = 0;
  endtask

  task automatic applyReset();
    Reset = 1'b0;
    clearInputs();
    repeat (2) @(posedge Clk);
    #3;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    total++; if (Gnt !== 3'b000) $display("FAIL reset_gnt got %b expected 000", Gnt); else passed++;
    total++; if (Sel !== 2'd0) $display("FAIL reset_sel got %0d expected 0", Sel); else passed++;
    total++; if (OutData !== 32'd0) $display("FAIL reset_outdata got %h expected 0", OutData); else passed++;
    total++; if (OutValid !== 1'b0) $display("FAIL reset_outvalid got %b expected 0", OutValid); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", Busy); else passed++;
    total++; if (Ready !== 3'b000) $display("FAIL reset_ready got %b expected 000", Ready); else passed++;
  endtask

  task automatic test_single_beat();
    applyReset();
    ReqA = 1; DataA = 32'h1111_0000; LastA = 1; OutReady = 1;
    tick();
    total++; if (Gnt !== 3'b001) $display("FAIL single_gnt got %b expected 001", Gnt); else passed++;
    total++; if (Busy !== 1'b1) $display("FAIL single_busy got %b expected 1", Busy); else passed++;
    total++; if (Ready !== 3'b001) $display("FAIL single_ready got %b expected 001", Ready); else passed++;
    tick();
    ReqA = 0;
    total++; if (OutData !== 32'h1111_0000) $display("FAIL single_outdata got %h expected 11110000", OutData); else passed++;
    total++; if (OutValid !== 1'b1) $display("FAIL single_outvalid got %b expected 1", OutValid); else passed++;
    total++; if (Gnt !== 3'b000) $display("FAIL single_release got %b expected 000", Gnt); else passed++;
    total++; if (Sel !== 2'd0) $display("FAIL single_sel_hold got %0d expected 0", Sel); else passed++;
    tick();
    total++; if (OutValid !== 1'b0) $display("FAIL single_drain got %b expected 0", OutValid); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL single_idle got %b expected 0", Busy); else passed++;
  endtask

  task automatic test_round_robin();
    logic [2:0] expGnt [7];
    logic [1:0] expSel [7];
    expGnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    expSel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    applyReset();
    ReqA = 1; ReqB = 1; ReqC = 1;
    LastA = 1; LastB = 1; LastC = 1;
    DataA = 32'hAAAA_0001; DataB = 32'hBBBB_0002; DataC = 32'hCCCC_0003;
    OutReady = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++; if (Gnt !== expGnt[i]) $display("FAIL rr_gnt[%0d] got %b expected %b", i, Gnt, expGnt[i]); else passed++;
      total++; if (Sel !== expSel[i]) $display("FAIL rr_sel[%0d] got %0d expected %0d", i, Sel, expSel[i]); else passed++;
    end
    // Last beat accepted on the edge after cycle index 4 was C's.
    total++; if (OutData !== 32'hCCCC_0003) $display("FAIL rr_data got %h expected cccc0003", OutData); else passed++;
    clearInputs();
  endtask

  task automatic test_max_beats();
    int beats;
    int guard;
    applyReset();
    ReqB = 1; ReqC = 1; LastB = 0; LastC = 1; OutReady = 1;
    DataB = 32'hB000_0000; DataC = 32'hC000_00FF;
    tick();
    total++; if (Gnt !== 3'b010) $display("FAIL max_first_gnt got %b expected 010", Gnt); else passed++;
    beats = 0;
    guard = 0;
    while (Gnt === 3'b010 && guard < 20) begin
      DataB = 32'hB000_0000 + 32'(beats);
      if (Ready[1] && ReqB) beats++;
      tick();
      guard++;
    end
    total++; if (beats != 8) $display("FAIL max_beat_count got %0d expected 8", beats); else passed++;
    total++; if (Gnt !== 3'b000) $display("FAIL max_release got %b expected 000", Gnt); else passed++;
    total++; if (OutData !== 32'hB000_0007) $display("FAIL max_last_data got %h expected b0000007", OutData); else passed++;
    tick();
    total++; if (Gnt !== 3'b100) $display("FAIL max_ptr_to_c got %b expected 100", Gnt); else passed++;
    clearInputs();
  endtask

  task automatic test_backpressure();
    applyReset();
    ReqA = 1; LastA = 0; OutReady = 1; DataA = 32'hA000_0001;
    tick();
    tick();
    total++; if (OutData !== 32'hA000_0001) $display("FAIL bp_first got %h expected a0000001", OutData); else passed++;
    OutReady = 0; DataA = 32'hA000_0002;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (Ready !== 3'b000) $display("FAIL bp_ready[%0d] got %b expected 000", k, Ready); else passed++;
      total++; if (OutData !== 32'hA000_0001) $display("FAIL bp_hold[%0d] got %h expected a0000001", k, OutData); else passed++;
      total++; if (OutValid !== 1'b1) $display("FAIL bp_valid[%0d] got %b expected 1", k, OutValid); else passed++;
      tick();
    end
    OutReady = 1;
    #1;
    total++; if (Ready !== 3'b001) $display("FAIL bp_ready_resume got %b expected 001", Ready); else passed++;
    tick();
    total++; if (OutData !== 32'hA000_0002) $display("FAIL bp_second got %h expected a0000002", OutData); else passed++;
    total++; if (Gnt !== 3'b001) $display("FAIL bp_still_owned got %b expected 001", Gnt); else passed++;
    clearInputs();
  endtask

  task automatic test_owner_drop();
    applyReset();
    ReqA = 1; LastA = 0; OutReady = 1; DataA = 32'hD000_0001;
    tick();
    tick();
    OutReady = 0; ReqA = 0;
    tick();
    total++; if (Gnt !== 3'b000) $display("FAIL drop_release got %b expected 000", Gnt); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL drop_busy got %b expected 0", Busy); else passed++;
    total++; if (OutValid !== 1'b1) $display("FAIL drop_retained got %b expected 1", OutValid); else passed++;
    ReqB = 1; LastB = 1; DataB = 32'hB000_0009;
    tick();
    total++; if (Gnt !== 3'b010) $display("FAIL drop_regrant got %b expected 010", Gnt); else passed++;
    total++; if (OutData !== 32'hD000_0001) $display("FAIL drop_persist got %h expected d0000001", OutData); else passed++;
    total++; if (Ready !== 3'b000) $display("FAIL drop_blocked got %b expected 000", Ready); else passed++;
    OutReady = 1;
    #1;
    total++; if (Ready !== 3'b010) $display("FAIL drop_ready_b got %b expected 010", Ready); else passed++;
    tick();
    total++; if (OutData !== 32'hB000_0009) $display("FAIL drop_b_data got %h expected b0000009", OutData); else passed++;
    clearInputs();
  endtask

  task automatic test_async_reset();
    applyReset();
    ReqA = 1; LastA = 0; OutReady = 0; DataA = 32'hE000_0001;
    tick();
    tick();
    total++; if (OutValid !== 1'b1) $display("FAIL ar_setup_valid got %b expected 1", OutValid); else passed++;
    #2;
    Reset = 1'b0;
    #1;
    total++; if (Gnt !== 3'b000) $display("FAIL ar_gnt got %b expected 000", Gnt); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL ar_busy got %b expected 0", Busy); else passed++;
    total++; if (OutValid !== 1'b0) $display("FAIL ar_valid got %b expected 0", OutValid); else passed++;
    total++; if (OutData !== 32'd0) $display("FAIL ar_data got %h expected 0", OutData); else passed++;
    total++; if (Ready !== 3'b000) $display("FAIL ar_ready got %b expected 000", Ready); else passed++;
    @(negedge Clk);
    ReqA = 1; ReqC = 1; LastA = 1; OutReady = 1;
    Reset = 1'b1;
    tick();
    total++; if (Gnt !== 3'b001) $display("FAIL ar_first_grant got %b expected 001", Gnt); else passed++;
    clearInputs();
  endtask

  initial begin
    Reset = 1'b0;
    clearInputs();
    test_reset();
    test_single_beat();
    test_round_robin();
    test_max_beats();
    test_backpressure();
    test_owner_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
